// File: rtl/cell_port_arbiter.sv
// Four-requester round-robin port arbiter with a per-grant hold limit.
// A grant lasts until the owner drops its request (release) or until it has
// held the port for HOLD_MAX consecutive cycles (timeout, flagged by a
// one-cycle expired pulse). After either event the round-robin search starts
// just past the most recent winner, so a timed-out owner is re-granted only
// when nobody else is waiting.
module cell_port_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       expired
);

    // Last hold count at which the owner may still keep the port.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         idx_reg, idx_next;
    logic [1:0]         last_reg, last_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic               expired_reg, expired_next;
    logic [3:0]         gnt_reg, gnt_next;
    logic               valid_next;

    // Round-robin search result
    logic [1:0]         win_idx;
    logic               win_found;
    logic [1:0]         cand;

    // Round-robin search: LAST+1, LAST+2, LAST+3, then LAST itself.
    always_comb begin
        win_idx   = last_reg;
        win_found = 1'b0;
        cand      = last_reg;
        for (int k = 1; k <= 4; k++) begin
            cand = last_reg + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: idle arbitration, hold counting, release and timeout.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        expired_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next    = GRANT;
                    idx_next      = win_idx;
                    last_next     = win_idx;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (req[idx_reg]) begin
                    if (hold_cnt_reg < HOLD_LAST) begin
                        // Owner keeps the port for another cycle.
                        hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                    end else begin
                        // Timeout: owner is still requesting, so the search
                        // always finds someone (the owner itself at worst).
                        expired_next  = 1'b1;
                        idx_next      = win_idx;
                        last_next     = win_idx;
                        hold_cnt_next = '0;
                    end
                end else if (win_found) begin
                    // Release with another requester waiting: hand over
                    // directly with no idle cycle. Never flagged as timeout.
                    idx_next      = win_idx;
                    last_next     = win_idx;
                    hold_cnt_next = '0;
                end else begin
                    state_next    = IDLE;
                    idx_next      = '0;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                idx_next      = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    assign valid_next = (state_next == GRANT);

    // One-hot grant decode of the next index, gated by next validity.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gnt_dec
            assign gnt_next[gi] = valid_next && (idx_next == 2'(gi));
        end
    endgenerate

    // State and output registers; reset clears the grant without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            last_reg     <= 2'd3;
            hold_cnt_reg <= '0;
            expired_reg  <= 1'b0;
            gnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            expired_reg  <= expired_next;
            gnt_reg      <= gnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = idx_reg;
    assign gnt_valid = (state_reg == GRANT);
    assign expired   = expired_reg;

endmodule

// File: tb/tb_cell_port_arbiter.sv
// Directed bench for cell_port_arbiter with HOLD_MAX = 4. Each step drives
// req on the falling edge, queues the expected outputs, and after the next
// rising edge pops and compares {gnt, gnt_idx, gnt_valid, expired}.
module tb_cell_port_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       expired;

    int n_checks;
    int n_fail;
    int step_no;

    logic [7:0] exp_q[$];

    cell_port_arbiter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector built from a one-hot (or zero) grant.
    function automatic logic [7:0] pack_exp(input logic [3:0] g, input logic e);
        logic [1:0] ix;
        ix = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) ix = 2'(i);
        return {g, ix, |g, e};
    endfunction

    task automatic push_exp(input logic [3:0] g, input logic e);
        exp_q.push_back(pack_exp(g, e));
    endtask

    task automatic check(input string tag);
        logic [7:0] obs;
        logic [7:0] want;
        obs = {gnt, gnt_idx, gnt_valid, expired};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s step %0d: scoreboard empty, observed %b", tag, step_no, obs);
        end else begin
            want = exp_q.pop_front();
            n_checks++;
            assert (obs === want) else begin
                n_fail++;
                $error("FAIL %s step %0d: observed gnt/idx/valid/exp=%b required %b",
                       tag, step_no, obs, want);
            end
        end
        $display("step %0d %s req=%b gnt=%b idx=%0d valid=%b expired=%b",
                 step_no, tag, req, gnt, gnt_idx, gnt_valid, expired);
        step_no++;
    endtask

    // One clocked transaction: drive, queue expectation, clock, compare.
    task automatic cyc(input string tag, input logic [3:0] r,
                       input logic [3:0] eg, input logic ee);
        @(negedge clk);
        req = r;
        push_exp(eg, ee);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        req   = 4'b0000;
        reset = 1'b1;
        #1;
        push_exp(4'b0000, 1'b0);
        check(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        step_no  = 0;
        req      = 4'b0000;
        reset    = 1'b1;
        #2;
        push_exp(4'b0000, 1'b0);
        check("reset_async");

        // Reset held with no requests for 10 cycles.
        for (int i = 0; i < 10; i++) cyc("reset_hold", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Idle with no requests stays idle.
        cyc("idle_quiet", 4'b0000, 4'b0000, 1'b0);
        cyc("idle_quiet", 4'b0000, 4'b0000, 1'b0);

        // Grant, direct handover on release, then back to idle.
        cyc("grant_first", 4'b0101, 4'b0001, 1'b0);
        cyc("handover",    4'b0100, 4'b0100, 1'b0);
        cyc("release_idle", 4'b0000, 4'b0000, 1'b0);

        // Non-owner activity does not disturb the owner.
        cyc("own_start", 4'b0001, 4'b0001, 1'b0);
        cyc("own_noise", 4'b1111, 4'b0001, 1'b0);
        cyc("own_noise", 4'b0011, 4'b0001, 1'b0);
        cyc("own_drop",  4'b0010, 4'b0010, 1'b0);
        cyc("own_drop",  4'b0000, 4'b0000, 1'b0);

        // All requesting: rotation every HOLD_MAX cycles with expiry pulses.
        pulse_reset("reset_pulse");
        for (int e = 1; e <= 20; e++) begin
            cyc("rotate", 4'b1111, 4'(1 << (((e - 1) / HOLD_MAX) % 4)),
                (e > 1) && ((e - 1) % HOLD_MAX == 0));
        end

        // Lone requester: re-granted on each timeout, expiry still pulses.
        pulse_reset("reset_pulse");
        for (int e = 1; e <= 12; e++) begin
            cyc("regrant", 4'b0010, 4'b0010, (e > 1) && ((e - 1) % HOLD_MAX == 0));
        end

        // Owner releases at the timeout edge: handover, no expiry.
        pulse_reset("reset_pulse");
        for (int e = 1; e <= HOLD_MAX; e++) cyc("hold_full", 4'b0001, 4'b0001, 1'b0);
        cyc("release_at_limit", 4'b0100, 4'b0100, 1'b0);
        cyc("after_release",    4'b0100, 4'b0100, 1'b0);

        // Reset mid-grant clears immediately; priority restarts at 0.
        pulse_reset("reset_pulse");
        cyc("grant_3", 4'b1000, 4'b1000, 1'b0);
        pulse_reset("reset_mid_grant");
        cyc("restart_prio", 4'b1001, 4'b0001, 1'b0);
        cyc("restart_drop", 4'b0000, 4'b0000, 1'b0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed stall required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cell_port_arbiter.md
CELL_PORT_ARBITER -- requirements
Module: cell_port_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15: maximum consecutive cycles one requester may hold the grant; legal range 1..255.
REQ-002 Parameter CNT_W, default 8: width of the hold counter; CNT_W SHALL be large enough to hold HOLD_MAX-1.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 REQ  input  4  per-requester request; bit n is requester n.
REQ-006 GNT  output  4  one-hot grant, or all-zero when no grant; registered.
REQ-007 GNT_IDX  output  2  binary index of the granted requester; registered.
REQ-008 GNT_VALID  output  1  high when any GNT bit is high; registered.
REQ-009 EXPIRED  output  1  one-cycle pulse when a grant ends by timeout; registered.

Function
REQ-010 State machine with two states: IDLE (no grant) and GRANT (one requester owns the port).
REQ-011 GNT SHALL always equal the 2-to-4 decode of GNT_IDX, gated by GNT_VALID; more than one GNT bit SHALL never be high.
REQ-012 LAST register (2 bits) holds the index of the most recent grant.
REQ-013 Arbitration order: search from LAST+1 upward, modulo 4, ending at LAST; the first index with REQ high wins.
REQ-014 IDLE, any REQ high at an edge: after that edge, state = GRANT, GNT_IDX = winner, LAST = winner, HOLD_CNT = 0. Latency is 1 cycle from sampled REQ to GNT.
REQ-015 IDLE, REQ = 0000: the block SHALL remain in IDLE with all outputs low.
REQ-016 GRANT, REQ[GNT_IDX] high and HOLD_CNT < HOLD_MAX-1: HOLD_CNT increments and the grant is held.
REQ-017 Release occurs in GRANT when REQ[GNT_IDX] is low at an edge: if another REQ is high, the block SHALL switch directly to the winner of REQ-013, with no idle gap and HOLD_CNT = 0; otherwise it SHALL go to IDLE with GNT = 0000.
REQ-018 Timeout occurs in GRANT when REQ[GNT_IDX] is high and HOLD_CNT = HOLD_MAX-1 at an edge: EXPIRED = 1 for the next cycle, then arbitration proceeds per REQ-013.
REQ-019 A requester that times out with no other requester pending SHALL be re-granted: GNT is unchanged, HOLD_CNT = 0, and EXPIRED still pulses.
REQ-020 A release and a timeout at the same edge (REQ[GNT_IDX] low while HOLD_CNT = HOLD_MAX-1) SHALL be treated as a release, with EXPIRED = 0.
REQ-021 With HOLD_MAX = 1, every granted cycle while the owner is still requesting is a timeout edge.
REQ-022 REQ changes on non-owner bits SHALL NOT affect the current grant before release or timeout.
REQ-023 HOLD_CNT SHALL never exceed HOLD_MAX-1 and SHALL never wrap.
REQ-024 EXPIRED SHALL be low in every cycle other than the one following a timeout edge.

Reset
REQ-025 While RESET is high, regardless of CLK: state = IDLE, GNT = 0000, GNT_IDX = 00, GNT_VALID = 0, EXPIRED = 0, HOLD_CNT = 0, LAST = 3.
REQ-026 Reset asserted mid-grant SHALL drop GNT immediately, without waiting for a clock edge.
REQ-027 After reset, arbitration priority SHALL restart at requester 0.
REQ-028 The first edge after RESET deasserts SHALL perform normal IDLE arbitration on the sampled REQ.

Verification
REQ-029 Reset with REQ = 0000 for 10 cycles -> GNT = 0000, GNT_VALID = 0, EXPIRED = 0 throughout.
REQ-030 After reset, REQ = 0101 -> GNT = 0001 one cycle later; drop REQ[0] -> GNT = 0100 on the next cycle with no zero cycle between; drop REQ[2] -> GNT = 0000.
REQ-031 HOLD_MAX = 4, REQ = 1111 held -> GNT sequence 0001, 0010, 0100, 1000, 0001, with 4 cycles each; EXPIRED pulses once at each change.
REQ-032 HOLD_MAX = 4, REQ = 0010 held for 12 cycles -> GNT = 0010 continuously, with an EXPIRED pulse every 4 cycles.
REQ-033 RESET pulsed between edges while GNT = 1000 -> GNT = 0000 before the next edge; REQ = 1001 after release -> GNT = 0001.
REQ-034 HOLD_MAX = 4, owner drops REQ at the edge where HOLD_CNT = 3 and REQ = 0100 is pending -> GNT = 0100 and EXPIRED stays 0.
